// File: rtl/spi_pkg.sv
// Shared SPI command-layer types: command codes, register layouts and handler FSM states.
package spi_pkg;

  typedef enum logic [7:0] {
    CMD_VERSION           = 8'h00,
    CMD_READ_CONTACTOR    = 8'h01,
    CMD_READ_FEEDBACK     = 8'h02,
    CMD_READ_STATUS       = 8'h03,
    CMD_READ_SHUTDOWN     = 8'h04,
    CMD_WRITE_CONTACTOR   = 8'h81,
    CMD_WRITE_CONTROL     = 8'h82,
    CMD_WRITE_SHUTDOWN    = 8'h83,
    CMD_WRITE_PG_SHUTDOWN = 8'h84
  } spi_cmd_t;

  typedef struct packed {
    logic       feedback_timeout_error;
    logic       invalid_request;
    logic [5:0] rsvd;
  } status_reg_t;

  // Only the two defined control bits (data[7:6]); data[5:0] are reserved.
  typedef struct packed {
    logic reset_req;
    logic clear_errors;
  } control_reg_t;

  typedef struct packed {
    logic plus;
    logic minus;
  } contactor_data_t;

  typedef enum logic [1:0] {IDLE, ARG, DATA, DONE} handler_state_t;

  localparam int         SPI_FRAME_BYTES = 3;
  localparam logic [7:0] SPI_RESP_PAD    = 8'h00;

  function automatic logic is_known_cmd(input logic [7:0] c);
    case (c)
      CMD_VERSION, CMD_READ_CONTACTOR, CMD_READ_FEEDBACK, CMD_READ_STATUS,
      CMD_READ_SHUTDOWN, CMD_WRITE_CONTACTOR, CMD_WRITE_CONTROL,
      CMD_WRITE_SHUTDOWN, CMD_WRITE_PG_SHUTDOWN: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_index(input logic [7:0] c);
    case (c)
      CMD_READ_CONTACTOR, CMD_READ_FEEDBACK, CMD_WRITE_CONTACTOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_status_reg.sv
// Sticky error flags; a set in the same cycle as a clear leaves the flag set.
module spi_status_reg
  import spi_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_set_fb_timeout,
  input  logic        i_set_invalid,
  input  logic        i_clear,
  output status_reg_t o_status
);

  logic r_fb_timeout;
  logic r_invalid;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fb_timeout <= 1'b0;
      r_invalid    <= 1'b0;
    end else begin
      r_fb_timeout <= i_set_fb_timeout | (r_fb_timeout & ~i_clear);
      r_invalid    <= i_set_invalid    | (r_invalid    & ~i_clear);
    end
  end

  assign o_status = '{feedback_timeout_error: r_fb_timeout,
                      invalid_request:        r_invalid,
                      rsvd:                   6'b0};

endmodule

// File: rtl/spi_cmd_handler.sv
// SPI command layer: decodes 3-byte CMD/ARG/DATA frames, holds command registers
// and returns one response byte per received byte.
module spi_cmd_handler
  import spi_pkg::*;
#(
  parameter int         NUM_CONTACTORS = 8,
  parameter logic [7:0] FPGA_VERSION   = 8'h01
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_cs_active,
  input  logic                        i_rx_valid,
  input  logic [7:0]                  i_rx_data,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_load,
  input  logic [2*NUM_CONTACTORS-1:0] i_contactor_fb,
  input  logic                        i_shutdown_status,
  input  logic                        i_fb_timeout_pulse,
  output logic [2*NUM_CONTACTORS-1:0] o_contactor_cmd,
  output logic                        o_shutdown_req,
  output logic                        o_pg_shutdown,
  output logic                        o_reset_req
);

  localparam int         IDX_W = (NUM_CONTACTORS > 1) ? $clog2(NUM_CONTACTORS) : 1;
  localparam logic [8:0] NUM_C = 9'(NUM_CONTACTORS);

  handler_state_t                             r_state;
  logic                                       r_armed;
  logic [7:0]                                 r_cmd;
  logic [IDX_W-1:0]                           r_idx;
  logic                                       r_invalid;
  logic [7:0]                                 r_tx_data;
  logic                                       r_tx_load;
  contactor_data_t [NUM_CONTACTORS-1:0]       r_contactor;
  logic                                       r_shutdown_req;
  logic                                       r_pg_shutdown;
  logic                                       r_reset_req;

  contactor_data_t [NUM_CONTACTORS-1:0]       w_fb;
  status_reg_t                                w_status;
  control_reg_t                               w_ctrl;
  logic [IDX_W-1:0]                           w_rx_idx;
  logic                                       w_bad;
  logic                                       w_b2;
  logic                                       w_b3;
  logic                                       w_clear;
  logic [7:0]                                 w_rd_resp;

  assign w_fb     = i_contactor_fb;
  assign w_ctrl   = control_reg_t'(i_rx_data[7:6]);
  assign w_rx_idx = i_rx_data[IDX_W-1:0];
  assign w_b2     = i_cs_active && i_rx_valid && (r_state == ARG);
  assign w_b3     = i_cs_active && i_rx_valid && (r_state == DATA);
  // Byte-2 decode: r_cmd is already latched, the index is on the bus this cycle.
  assign w_bad    = !is_known_cmd(r_cmd) ||
                    (uses_index(r_cmd) && ({1'b0, i_rx_data} >= NUM_C));
  assign w_clear  = w_b3 && !r_invalid && (r_cmd == CMD_WRITE_CONTROL) && w_ctrl.clear_errors;

  spi_status_reg u_status (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_set_fb_timeout (i_fb_timeout_pulse),
    .i_set_invalid    (w_b2 && w_bad),
    .i_clear          (w_clear),
    .o_status         (w_status)
  );

  always_comb begin
    w_rd_resp = SPI_RESP_PAD;
    if (!w_bad) begin
      case (r_cmd)
        CMD_VERSION:        w_rd_resp = FPGA_VERSION;
        CMD_READ_CONTACTOR: w_rd_resp = {6'b0, r_contactor[w_rx_idx]};
        CMD_READ_FEEDBACK:  w_rd_resp = {6'b0, w_fb[w_rx_idx]};
        CMD_READ_STATUS:    w_rd_resp = w_status;
        CMD_READ_SHUTDOWN:  w_rd_resp = {7'b0, i_shutdown_status};
        default:            w_rd_resp = SPI_RESP_PAD;
      endcase
    end
  end

  // r_armed holds off a new frame after reset until CS has been seen low.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_armed        <= 1'b0;
      r_cmd          <= 8'h00;
      r_idx          <= '0;
      r_invalid      <= 1'b0;
      r_tx_data      <= 8'h00;
      r_tx_load      <= 1'b0;
      r_contactor    <= '0;
      r_shutdown_req <= 1'b0;
      r_pg_shutdown  <= 1'b0;
      r_reset_req    <= 1'b0;
    end else begin
      r_tx_load   <= 1'b0;
      r_reset_req <= 1'b0;
      if (!i_cs_active) begin
        r_state <= IDLE;
        r_armed <= 1'b1;
      end else if (i_rx_valid) begin
        case (r_state)
          IDLE: if (r_armed) begin
            r_cmd     <= i_rx_data;
            r_tx_data <= w_status;
            r_tx_load <= 1'b1;
            r_state   <= ARG;
          end
          ARG: begin
            r_idx     <= w_rx_idx;
            r_invalid <= w_bad;
            r_tx_data <= w_rd_resp;
            r_tx_load <= 1'b1;
            r_state   <= DATA;
          end
          DATA: begin
            r_tx_data <= SPI_RESP_PAD;
            r_tx_load <= 1'b1;
            r_state   <= DONE;
            if (!r_invalid) begin
              case (r_cmd)
                CMD_WRITE_CONTACTOR:   r_contactor[r_idx] <= i_rx_data[1:0];
                CMD_WRITE_CONTROL:     r_reset_req        <= w_ctrl.reset_req;
                CMD_WRITE_SHUTDOWN:    r_shutdown_req     <= i_rx_data[0];
                CMD_WRITE_PG_SHUTDOWN: r_pg_shutdown      <= i_rx_data[0];
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_tx_data       = r_tx_data;
  assign o_tx_load       = r_tx_load;
  assign o_contactor_cmd = r_contactor;
  assign o_shutdown_req  = r_shutdown_req;
  assign o_pg_shutdown   = r_pg_shutdown;
  assign o_reset_req     = r_reset_req;

endmodule
